// File: rtl/nibble_deserializer.sv
// rtl/nibble_deserializer.sv - framed serial-in/parallel-out receiver with valid/ready output
module nibble_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_en,
  input  logic             s_in,
  input  logic             dir,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, out_data_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             dir_q, dir_q_nx;
  logic             out_valid_nx, frame_err_nx, overrun_nx;
  logic             good_stop, bad_stop, load, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      dir_q     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      dir_q     <= dir_q_nx;
      out_data  <= out_data_nx;
      out_valid <= out_valid_nx;
      frame_err <= frame_err_nx;
      overrun   <= overrun_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    cnt_nx    = cnt;
    dir_q_nx  = dir_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (s_en) begin
      case (state)
        IDLE: begin
          if (!s_in) begin
            state_nx = DATA;
            cnt_nx   = '0;
            dir_q_nx = dir;
          end
        end
        DATA: begin
          // LSB-first fills from the top so the first bit lands in bit 0 after WIDTH shifts
          shreg_nx = dir_q ? {shreg[WIDTH-2:0], s_in} : {s_in, shreg[WIDTH-1:1]};
          cnt_nx   = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nx = STOP;
        end
        STOP: begin
          state_nx  = IDLE;
          good_stop = s_in;
          bad_stop  = !s_in;
        end
        default: state_nx = IDLE;
      endcase
    end

    accept       = out_valid && out_ready;
    load         = good_stop && (!out_valid || out_ready);
    out_data_nx  = load ? shreg : out_data;
    out_valid_nx = load ? 1'b1 : (accept ? 1'b0 : out_valid);

    // a new error event outranks a coincident clear
    frame_err_nx = bad_stop ? 1'b1 : (clr_err ? 1'b0 : frame_err);
    overrun_nx   = (good_stop && !load) ? 1'b1 : (clr_err ? 1'b0 : overrun);
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
- Serial-in/parallel-out receiver for the framed serial stream produced by the 4-bit shifting register's serial output.
- Detects a start bit, shifts in WIDTH data bits (LSB- or MSB-first), and checks the stop bit.
- Presents each good word on a parallel port with a valid/ready handshake.
- Sits downstream of the shift register on the same clock and is the receive end of its serial link.

Parameters:
WIDTH, 4, number of data bits per frame (legal range 2..8).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
s_en  input  1  bit-strobe; the line is sampled and the FSM advances only on cycles with s_en=1.
s_in  input  1  serial line; idles high.
dir  input  1  0 = LSB-first, 1 = MSB-first; sampled with the start bit.
out_data  output  WIDTH  received word.
out_valid  output  1  out_data holds an unconsumed word.
out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
busy  output  1  high while a frame is in progress (state != IDLE).
frame_err  output  1  sticky: stop bit was sampled as 0.
overrun  output  1  sticky: a good frame completed while the holding register was full and not being accepted.
clr_err  input  1  synchronous pulse that clears frame_err and overrun.

Behaviour:
Reset:
- rst_n=0 asynchronously forces state=IDLE, shift register=0, bit counter=0, out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- Reset applies immediately, including mid-frame; the partial frame is discarded.

FSM states: IDLE, DATA, STOP. All transitions require s_en=1; with s_en=0 all state holds.
- IDLE: s_in=0 -> DATA, counter=0, latch dir into dir_q. s_in=1 -> stay.
- DATA: shift in s_in and increment the counter.
  - dir_q=0: shift right, new bit enters the MSB; after WIDTH bits the first-received bit is the LSB.
  - dir_q=1: shift left, new bit enters the LSB.
  - When counter reaches WIDTH-1 on a strobe -> STOP.
- STOP, s_in=1 (good frame) -> IDLE:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: out_data <= shift register, out_valid=1 on the next edge.
  - Otherwise the word is dropped, out_data is unchanged, and overrun sets.
- STOP, s_in=0 -> IDLE, word dropped, frame_err sets. The next strobe with s_in=0 in IDLE is treated as a new start bit.

Handshake:
- Accept happens when out_valid and out_ready are both 1 at a rising edge.
- On an accept with no simultaneous load: out_valid=0 next cycle, and out_data holds its last value.
- On an accept with a simultaneous load: out_valid stays 1 and out_data takes the new word, with no bubble.
- out_data changes only on a load.

Latency: out_valid rises on the edge that samples the stop bit, i.e. it is visible in the cycle after the stop-bit strobe.

Status:
- busy is combinational from state.
- clr_err clears both sticky flags on the next edge.
- If clr_err coincides with a new error event, the set wins.
- dir changes mid-frame have no effect; only dir_q, latched at the start bit, is used.

Test Plan:
1. Reset, then LSB-first frame (dir=0, s_en=1 every cycle) with s_in sequence 0,1,0,1,1,1 (start, data 1,0,1,1, stop) -> out_valid=1 one cycle after stop, out_data=4'hD, busy high for 5 cycles, no flags set.
2. Same bit sequence with dir=1 -> out_data=4'hB. A second frame with dir toggled mid-frame -> order follows the dir value latched at start.
3. s_en pulsed every 3rd cycle, frame 0,0,0,0,1,1 with dir=0 -> out_data=4'h8; FSM holds on every non-strobe cycle.
4. Hold out_ready=0 while receiving 4'h3 then 4'hA -> out_data stays 4'h3 and overrun=1. Pulse clr_err -> overrun=0. Then assert out_ready in the same cycle as the stop strobe of 4'h5 -> out_valid stays 1 and out_data=4'h5.
5. Frame whose stop bit is 0 -> frame_err=1, out_valid unchanged, FSM in IDLE. An immediately following valid frame is received correctly. clr_err coinciding with a second bad stop -> frame_err remains 1.
6. Assert rst_n=0 asynchronously (between clock edges) mid-DATA -> all outputs 0 immediately. After release, a full frame decodes correctly with no residue from the aborted frame.
